// File: rtl/audio_mix_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : audio_mix_pwm
//  Description : Mixes the SVF taps and the dry voice, applies master volume,
//                saturates to 8 bits and drives a 1-bit PWM pad output.
//                Also generates the once-per-period sample_tick.
//                Define AUDIO_MIX_DSM_EN for a first-order delta-sigma output.
//  Revision    : 1.0 - initial release
// ============================================================================
module audio_mix_pwm #(
    parameter int PRESCALE = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] audio_dry,
    input  logic [7:0] audio_hp,
    input  logic [7:0] audio_bp,
    input  logic [7:0] audio_lp,
    input  logic [3:0] mode,
    input  logic [3:0] volume,
    output logic       sample_tick,
    output logic       pwm_out,
    output logic [7:0] duty
);

    localparam int              c_pw         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_pw-1:0] c_presc_last = c_pw'(PRESCALE - 1);

    logic [c_pw-1:0]   r_presc;
    logic [7:0]        r_cnt;
    logic [7:0]        r_duty;
    logic              r_pwm;
    logic              r_tick;

    logic              w_adv;
    logic              w_wrap;
    logic [7:0]        w_cnt_new;
    logic [7:0]        w_duty_new;
    logic [7:0]        w_duty_next;
    logic              w_pwm_next;

    logic signed [13:0] w_dry_x;
    logic signed [13:0] w_hp_x;
    logic signed [13:0] w_bp_x;
    logic signed [13:0] w_lp_x;
    logic signed [13:0] w_sum;
    logic signed [13:0] w_vol_x;
    logic signed [13:0] w_prod;
    logic signed [13:0] w_scaled;
    logic [7:0]         w_clamped;

    assign w_adv      = ena && (r_presc == c_presc_last);
    assign w_wrap     = w_adv && (r_cnt == 8'hFF);
    assign w_cnt_new  = r_cnt + 8'd1;
    assign w_duty_new = w_wrap ? w_duty_next : r_duty;

    // Sources are carried at product width; the sum itself never exceeds 10 bits.
    assign w_dry_x = mode[3] ? {{6{audio_dry[7]}}, audio_dry} : 14'sd0;
    assign w_hp_x  = mode[2] ? {{6{audio_hp[7]}},  audio_hp}  : 14'sd0;
    assign w_bp_x  = mode[1] ? {{6{audio_bp[7]}},  audio_bp}  : 14'sd0;
    assign w_lp_x  = mode[0] ? {{6{audio_lp[7]}},  audio_lp}  : 14'sd0;
    assign w_sum   = w_dry_x + w_hp_x + w_bp_x + w_lp_x;

    assign w_vol_x  = {10'd0, volume};
    assign w_prod   = w_sum * w_vol_x;
    assign w_scaled = w_prod >>> 4;

    always_comb begin
        w_clamped = w_scaled[7:0];
        if (w_scaled > 14'sd127) begin
            w_clamped = 8'h7F;
        end else if (w_scaled < -14'sd128) begin
            w_clamped = 8'h80;
        end
    end

    // Two's complement to offset binary: flip the sign bit.
    assign w_duty_next = {~w_clamped[7], w_clamped[6:0]};

`ifdef AUDIO_MIX_DSM_EN
    // The accumulator carry is registered directly as pwm_out, so only the
    // low eight accumulator bits need to be held here.
    logic [7:0] r_acc;
    logic [8:0] w_acc_next;

    assign w_acc_next = {1'b0, r_acc} + {1'b0, w_duty_new};
    assign w_pwm_next = w_acc_next[8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc <= 8'd0;
        end else if (w_adv) begin
            r_acc <= w_acc_next[7:0];
        end
    end
`else
    assign w_pwm_next = (w_cnt_new < w_duty_new);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_presc <= '0;
            r_cnt   <= 8'd0;
            r_duty  <= 8'h80;
            r_pwm   <= 1'b0;
            r_tick  <= 1'b0;
        end else begin
            r_tick <= w_wrap;
            if (!ena) begin
                r_pwm <= 1'b0;
            end else if (w_adv) begin
                r_presc <= '0;
                r_cnt   <= w_cnt_new;
                r_pwm   <= w_pwm_next;
                if (w_wrap) begin
                    r_duty <= w_duty_next;
                end
            end else begin
                r_presc <= r_presc + c_pw'(1);
            end
        end
    end

    assign sample_tick = r_tick;
    assign pwm_out     = r_pwm;
    assign duty        = r_duty;

endmodule
`default_nettype wire

// File: tb/tb_audio_mix_pwm.sv
`default_nettype none
// ============================================================================
//  Module      : tb_audio_mix_pwm
//  Description : Self-checking bench for audio_mix_pwm (PRESCALE=1 and =2).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_audio_mix_pwm;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic       ena2;
    logic [7:0] dry, hp, bp, lp;
    logic [3:0] mode, volume;
    logic       tick, pwm, tick2, pwm2;
    logic [7:0] duty, duty2;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0] mode;
        logic [3:0] vol;
        logic [7:0] dry;
        logic [7:0] hp;
        logic [7:0] bp;
        logic [7:0] lp;
        int         exp;
    } vec_t;

    vec_t vecs[13];
    vec_t garbage;

    audio_mix_pwm #(.PRESCALE(1)) dut (
        .clk(clk), .rst_n(rst_n), .ena(ena),
        .audio_dry(dry), .audio_hp(hp), .audio_bp(bp), .audio_lp(lp),
        .mode(mode), .volume(volume),
        .sample_tick(tick), .pwm_out(pwm), .duty(duty)
    );

    audio_mix_pwm #(.PRESCALE(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .ena(ena2),
        .audio_dry(dry), .audio_hp(hp), .audio_bp(bp), .audio_lp(lp),
        .mode(mode), .volume(volume),
        .sample_tick(tick2), .pwm_out(pwm2), .duty(duty2)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic [3:0] m, input logic [3:0] v,
                                input logic [7:0] d, input logic [7:0] h,
                                input logic [7:0] b, input logic [7:0] l,
                                input int e);
        vec_t r;
        r.mode = m; r.vol = v; r.dry = d; r.hp = h; r.bp = b; r.lp = l; r.exp = e;
        return r;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic apply(input vec_t v);
        mode = v.mode; volume = v.vol;
        dry = v.dry; hp = v.hp; bp = v.bp; lp = v.lp;
    endtask

    task automatic wait_tick(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (tick !== 1'b1 && n < limit);
        if (tick !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL tick_timeout: no sample_tick within %0d cycles", limit);
        end
    endtask

    int n, t1a, t1b, t2a, t2b, ticks1, errs, ones, d0;
    logic prev;

    initial begin
        vecs[0]  = mk(4'b0100, 4'd15, 8'h00, 8'd64, 8'h00, 8'h00, 188);
        vecs[1]  = mk(4'b1111, 4'd15, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 255);
        vecs[2]  = mk(4'b0001, 4'd15, 8'h7F, 8'h7F, 8'h7F, 8'h80, 8);
        vecs[3]  = mk(4'b0001, 4'd1,  8'h00, 8'h00, 8'h00, 8'hFF, 127);
        vecs[4]  = mk(4'b1111, 4'd0,  8'h7F, 8'h7F, 8'h7F, 8'h7F, 128);
        vecs[5]  = mk(4'b0000, 4'd15, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 128);
        vecs[6]  = mk(4'b1000, 4'd8,  8'd100, 8'hCE, 8'h00, 8'h00, 178);
        vecs[7]  = mk(4'b0011, 4'd15, 8'h00, 8'h00, 8'h9C, 8'h9C, 0);
        vecs[8]  = mk(4'b0110, 4'd15, 8'h00, 8'hC0, 8'h00, 8'h00, 68);
        vecs[9]  = mk(4'b0010, 4'd1,  8'h00, 8'h00, 8'hC0, 8'h00, 124);
        vecs[10] = mk(4'b0001, 4'd8,  8'h00, 8'h00, 8'h00, 8'h80, 64);
        vecs[11] = mk(4'b1100, 4'd15, 8'hFD, 8'h02, 8'h00, 8'h00, 127);
        vecs[12] = mk(4'b1010, 4'd15, 8'd60, 8'h00, 8'd60, 8'h00, 240);
        garbage  = mk(4'b1111, 4'd15, 8'h80, 8'h80, 8'h80, 8'h80, 0);

        rst_n = 1'b1; ena = 1'b1; ena2 = 1'b1;
        mode = 4'd0; volume = 4'd0; dry = 8'd0; hp = 8'd0; bp = 8'd0; lp = 8'd0;
        #3 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_duty",  int'(duty),  128);
        check("reset_pwm",   int'(pwm),   0);
        check("reset_tick",  int'(tick),  0);
        check("reset_duty2", int'(duty2), 128);
        check("reset_pwm2",  int'(pwm2),  0);
        check("reset_tick2", int'(tick2), 0);

        // Tick timing after release for both prescale settings.
        rst_n = 1'b1;
        t1a = -1; t1b = -1; t2a = -1; t2b = -1; ticks1 = 0; errs = 0;
        for (int k = 1; k <= 1100; k++) begin
            @(negedge clk);
            if (tick) begin
                ticks1++;
                if (t1a < 0) t1a = k; else if (t1b < 0) t1b = k;
            end
            if (tick2) begin
                if (t2a < 0) t2a = k; else if (t2b < 0) t2b = k;
            end
            if (duty !== 8'h80) errs++;
        end
        check("first_tick_p1",  t1a, 256);
        check("tick_period_p1", t1b - t1a, 256);
        check("first_tick_p2",  t2a, 512);
        check("tick_period_p2", t2b - t2a, 512);
        check("tick_count_p1",  ticks1, 4);
        check("idle_duty_errs", errs, 0);

        // Table-driven mix/volume/saturation vectors with PWM pattern checks.
        for (int v = 0; v < 13; v++) begin
            apply(vecs[v]);
            wait_tick(600, n);
            check($sformatf("duty_v%0d", v), int'(duty), vecs[v].exp);
            errs = 0; ones = 0; prev = 1'b0;
            for (int i = 0; i < 256; i++) begin
                if (i > 0) @(negedge clk);
                if (i == 128) apply(garbage);
                ones += int'(pwm);
`ifdef AUDIO_MIX_DSM_EN
                if (vecs[v].exp <= 128 && pwm && prev) errs++;
`else
                if (pwm !== (i < vecs[v].exp)) errs++;
`endif
                prev = pwm;
            end
            check($sformatf("ones_v%0d", v), ones, vecs[v].exp);
            check($sformatf("pattern_errs_v%0d", v), errs, 0);
            check($sformatf("duty_hold_v%0d", v), int'(duty), vecs[v].exp);
        end

        // ena low for 100 cycles mid-period.
        wait_tick(600, n);
        d0 = int'(duty);
        repeat (50) @(negedge clk);
        ena = 1'b0;
        errs = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (pwm !== 1'b0 || tick !== 1'b0 || int'(duty) != d0) errs++;
        end
        check("ena_low_errs", errs, 0);
        ena = 1'b1;
        wait_tick(600, n);
        check("ena_resume_remaining", n, 206);

        // Asynchronous reset mid-period with duty=200.
        apply(mk(4'b0001, 4'd12, 8'h00, 8'h00, 8'h00, 8'd96, 200));
        wait_tick(600, n);
        check("duty_200", int'(duty), 200);
        repeat (30) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("async_rst_duty",  int'(duty),  128);
        check("async_rst_pwm",   int'(pwm),   0);
        check("async_rst_tick",  int'(tick),  0);
        check("async_rst_duty2", int'(duty2), 128);
        @(negedge clk);
        rst_n = 1'b1;
        wait_tick(600, n);
        check("post_rst_first_tick", n, 256);
        check("post_rst_duty", int'(duty), 200);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
